burst_sequencer: RTL and testbench

BURST_SEQUENCER -- requirements
Module: burst_sequencer

---
 rtl/burst_sequencer.sv | 123 ++++++++++++
 tb/tb_burst_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sequencer.sv
// Burst sequencer: drives an external address generator through one full ascending-write or descending-read sweep.
// Optional carry/beat-count consistency checker is enabled by defining BURST_SEQ_CHECK_EN.
module burst_sequencer #(
  parameter int ad_w = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic          cmd_dir,
  output logic          cmd_ready,
  input  logic          abort,
  output logic          ag_reset,
  output logic          ag_preset,
  output logic          ag_en,
  output logic          ag_up_down,
  input  logic          ag_carry,
  output logic          mem_we,
  output logic          mem_re,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [ad_w:0] beats,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [ad_w:0] beat_max  = {1'b1, {ad_w{1'b0}}};
  localparam logic [ad_w:0] beat_last = {1'b0, {ad_w{1'b1}}};

  state_t state;
  logic   dir;

  // Status decoded from state only; cmd_ready is additionally held low while reset is asserted.
  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  // NOTE: every strobe is a register loaded one edge ahead, so abort and cmd_valid
  // can only affect outputs after a clock edge, never through a combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= 1'b0;
      beats      <= '0;
      ag_reset   <= 1'b1;
      ag_preset  <= 1'b0;
      ag_en      <= 1'b0;
      ag_up_down <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      ag_reset  <= 1'b0;
      ag_preset <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= LOAD;
            dir       <= cmd_dir;
            beats     <= '0;
            ag_reset  <= cmd_dir;
            ag_preset <= !cmd_dir;
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= IDLE;
            ag_reset <= 1'b1;
            aborted  <= 1'b1;
          end else begin
            state      <= RUN;
            ag_en      <= 1'b1;
            ag_up_down <= dir;
            mem_we     <= dir;
            mem_re     <= !dir;
          end
        end
        RUN: begin
          // Abort outranks carry: the access under abort is dropped and not counted.
          if (abort) begin
            state      <= IDLE;
            ag_reset   <= 1'b1;
            aborted    <= 1'b1;
            ag_en      <= 1'b0;
            ag_up_down <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
          end else begin
            if (beats != beat_max) beats <= beats + 1'b1;
            if (ag_carry) begin
              state      <= DONE;
              done       <= 1'b1;
              ag_en      <= 1'b0;
              ag_up_down <= 1'b0;
              mem_we     <= 1'b0;
              mem_re     <= 1'b0;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BURST_SEQ_CHECK_EN
  // During the last beat of a sweep the count reads 2**ad_w-1; carry must coincide with it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == RUN &&
                 ((ag_carry && beats != beat_last) || (!ag_carry && beats == beat_last))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer: table-driven bursts, randomized bursts against a burst-level model,
// and hand sequences for reset and the BURST_SEQ_CHECK_EN carry checker.
module tb_burst_sequencer;

  localparam int ad_w = 4;
  localparam int full = 1 << ad_w;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_ready, ag_reset, ag_preset, ag_en, ag_up_down, ag_carry;
  logic          mem_we, mem_re, busy, done, aborted, err;
  logic [ad_w:0] beats;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  burst_sequencer #(.ad_w(ad_w)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_ready(cmd_ready),
    .abort(abort), .ag_reset(ag_reset), .ag_preset(ag_preset), .ag_en(ag_en),
    .ag_up_down(ag_up_down), .ag_carry(ag_carry), .mem_we(mem_we), .mem_re(mem_re),
    .busy(busy), .done(done), .aborted(aborted), .beats(beats), .err(err)
  );

  // Ideal address generator: clears when disabled, flags the last address of the sweep.
  logic [ad_w-1:0] gen_addr;
  logic            carry_force = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           gen_addr <= '0;
    else if (ag_reset)   gen_addr <= '0;
    else if (ag_preset)  gen_addr <= '1;
    else if (!ag_en)     gen_addr <= '0;
    else if (ag_up_down) gen_addr <= gen_addr + 1'b1;
    else                 gen_addr <= gen_addr - 1'b1;
  end

  assign ag_carry = carry_force | (ag_up_down ? (gen_addr == '1) : (gen_addr == '0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Burst-level reference: abort_at 0 = during LOAD, k = during k-th RUN cycle, -1 = none.
  function automatic int model_beats(input int abort_at, input int force_at);
    if (abort_at >= 0) return (abort_at == 0) ? 0 : abort_at - 1;
    if (force_at > 0)  return force_at;
    return full;
  endfunction

  task automatic run_burst(input logic dir, input int abort_at, input int force_at, input bit noise,
                           input int exp_beats, input bit exp_done, input bit exp_aborted,
                           input string tag);
    int  done_c;
    bit  ab_seen;
    bit  wrong_strobe;
    bit  addr_ok;
    int  committed;
    int  j;
    done_c = -1; ab_seen = 0; wrong_strobe = 0; addr_ok = 1; committed = 0; j = 0;
    @(negedge clk);
    check({tag, ".ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    abort     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_dir     = noise ? 1'($urandom_range(0, 1)) : dir;
      abort       = (c - 1 == abort_at);
      carry_force = (force_at > 0) && (c - 1 == force_at);
      if (c == 1) begin
        check({tag, ".load_reset"}, ag_reset, dir);
        check({tag, ".load_preset"}, ag_preset, !dir);
        check({tag, ".load_en"}, ag_en, 0);
        check({tag, ".load_busy"}, busy, 1);
      end
      if (mem_we || mem_re) begin
        if (mem_we != dir || mem_re != !dir || !ag_en || ag_up_down != dir) wrong_strobe = 1;
        if (int'(gen_addr) != (dir ? j : full - 1 - j)) addr_ok = 0;
        j++;
        if (!abort) committed++;
      end
      if (done) begin
        done_c = c;
        check({tag, ".done_beats"}, beats, exp_beats);
        check({tag, ".done_busy"}, busy, 1);
        cmd_valid = 1'b0;
        abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        carry_force = 1'b0;
        break;
      end
      if (aborted) begin
        ab_seen = 1;
        check({tag, ".abort_beats"}, beats, exp_beats);
        check({tag, ".abort_agreset"}, ag_reset, 1);
        check({tag, ".abort_nostrobe"}, {mem_we, mem_re, ag_en}, 0);
        cmd_valid = 1'b0;
        abort = 1'b0;
        carry_force = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    carry_force = 1'b0;
    check({tag, ".done_seen"}, done_c >= 0, exp_done);
    check({tag, ".aborted_seen"}, ab_seen, exp_aborted);
    check({tag, ".accesses"}, committed, exp_beats);
    check({tag, ".addr_order"}, addr_ok, 1);
    check({tag, ".strobe_dir"}, wrong_strobe, 0);
    if (exp_done && done_c >= 0) check({tag, ".done_cycle"}, done_c, exp_beats + 2);
    @(negedge clk);
    abort = 1'b0;
    check({tag, ".idle_ready"}, cmd_ready, 1);
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_pulses"}, {done, aborted, ag_reset}, 0);
    check({tag, ".idle_beats"}, beats, exp_beats);
  endtask

  typedef struct {
    logic  dir;
    int    abort_at;
    int    exp_beats;
    bit    exp_done;
    bit    exp_aborted;
    string name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, -1,   16, 1'b1, 1'b0, "asc_full"};
    vecs[1] = '{1'b0, -1,   16, 1'b1, 1'b0, "desc_full"};
    vecs[2] = '{1'b1,  5,    4, 1'b0, 1'b1, "asc_abort5"};
    vecs[3] = '{1'b0,  5,    4, 1'b0, 1'b1, "desc_abort5"};
    vecs[4] = '{1'b1, 16,   15, 1'b0, 1'b1, "asc_abort_carry"};
    vecs[5] = '{1'b0, 16,   15, 1'b0, 1'b1, "desc_abort_carry"};
    vecs[6] = '{1'b1,  0,    0, 1'b0, 1'b1, "abort_load"};
    vecs[7] = '{1'b0,  1,    0, 1'b0, 1'b1, "abort_run1"};

    // Reset state
    #12;
    check("rst.ag_reset", ag_reset, 1);
    check("rst.cmd_ready", cmd_ready, 0);
    check("rst.controls", {ag_preset, ag_en, ag_up_down, mem_we, mem_re}, 0);
    check("rst.status", {busy, done, aborted, err}, 0);
    check("rst.beats", beats, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_burst(vecs[i].dir, vecs[i].abort_at, -1, 1'b0, vecs[i].exp_beats,
                vecs[i].exp_done, vecs[i].exp_aborted, vecs[i].name);

    for (int i = 0; i < 24; i++) begin
      logic d;
      int   ab;
      d  = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, full)) : -1;
      run_burst(d, ab, -1, 1'b1, model_beats(ab, -1), ab < 0, ab >= 0, "rand");
    end

    // Asynchronous reset between edges in the middle of RUN
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.ag_reset", ag_reset, 1);
    check("midrst.strobes", {ag_en, mem_we, mem_re, ag_preset}, 0);
    check("midrst.status", {busy, cmd_ready, done, aborted}, 0);
    check("midrst.beats", beats, 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit pulse;
      pulse = 0;
      repeat (3) begin
        @(negedge clk);
        if (done || aborted || busy) pulse = 1;
      end
      check("midrst.no_pulse", pulse, 0);
    end
    run_burst(1'b1, -1, -1, 1'b0, full, 1'b1, 1'b0, "post_reset");
    check("err.clean", err, 0);

`ifdef BURST_SEQ_CHECK_EN
    run_burst(1'b1, -1, 11, 1'b0, model_beats(-1, 11), 1'b1, 1'b0, "force_carry");
    check("err.set", err, 1);
    run_burst(1'b0, -1, -1, 1'b0, full, 1'b1, 1'b0, "after_force");
    check("err.sticky", err, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("err.cleared", err, 0);
    @(negedge clk);
    reset = 1'b0;
`else
    run_burst(1'b0, -1, -1, 1'b0, full, 1'b1, 1'b0, "no_checker");
    check("err.tied", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
